mem_init_loader: RTL

- Byte-stream program loader upstream of the core's external memory-init ports (instruction and data memory load buses, shared load enable).
- Parses framed commands from a byte source (UART RX or testbench) and assembles little-endian 32-bit word pairs.
- Issues one write strobe per pair to the instruction or data memory.
- Holds the core stalled via core_hold until a RUN command arrives.

---
 rtl/mem_init_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_init_loader.sv
// ============================================================================
// mem_init_loader : byte-stream program loader for instruction/data memories
// Optional trailing-checksum frame byte via `define LOADER_CHECKSUM_EN. Rev 1.0
// ============================================================================
`default_nettype none

module mem_init_loader #(
    parameter int DATA    = 32,
    parameter int ADDRESS = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               inst_we,
    output logic [ADDRESS-1:0] inst_addr,
    output logic [DATA-1:0]    inst_d1,
    output logic [DATA-1:0]    inst_d2,
    output logic               data_we,
    output logic [ADDRESS-1:0] data_addr,
    output logic [DATA-1:0]    data_d1,
    output logic [DATA-1:0]    data_d2,
    output logic               load_en,
    output logic               core_hold,
    output logic               busy,
    output logic               err
);

    localparam logic [7:0] c_HDR_INST = 8'h01;
    localparam logic [7:0] c_HDR_DATA = 8'h02;
    localparam logic [7:0] c_HDR_RUN  = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_LO = 3'd1,
        S_ADDR_HI = 3'd2,
        S_CNT_LO  = 3'd3,
        S_CNT_HI  = 3'd4,
        S_PAYLOAD = 3'd5,
        S_WRITE   = 3'd6,
        S_CHK     = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    state_t                w_frame_end;
    logic                  r_tgt_data;
    logic [7:0]            r_addr_lo;
    logic [ADDRESS-1:0]    r_addr;
    logic [15:0]           r_cnt;
    logic [2:0]            r_bcnt;
    logic [2*DATA-9:0]     r_pair;
    logic [ADDRESS-1:0]    r_inst_addr, r_data_addr;
    logic [DATA-1:0]       r_inst_d1, r_inst_d2, r_data_d1, r_data_d2;
    logic                  r_hold;
    logic                  r_err;
    logic                  w_xfer;
    logic [2*DATA-1:0]     w_pair_next;
    logic [15:0]           w_cnt_full;

    assign in_ready    = (r_state != S_WRITE);
    assign w_xfer      = in_valid & in_ready;
    assign w_pair_next = {in_data, r_pair};
    assign w_cnt_full  = {in_data, r_cnt[7:0]};

`ifdef LOADER_CHECKSUM_EN
    assign w_frame_end = S_CHK;
`else
    assign w_frame_end = S_IDLE;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_xfer && (in_data == c_HDR_INST || in_data == c_HDR_DATA))
                           w_next = S_ADDR_LO;
            S_ADDR_LO: if (w_xfer) w_next = S_ADDR_HI;
            S_ADDR_HI: if (w_xfer) w_next = S_CNT_LO;
            S_CNT_LO:  if (w_xfer) w_next = S_CNT_HI;
            S_CNT_HI:  if (w_xfer) w_next = (w_cnt_full == 16'd0) ? w_frame_end : S_PAYLOAD;
            S_PAYLOAD: if (w_xfer && r_bcnt == 3'd7) w_next = S_WRITE;
            S_WRITE:   w_next = (r_cnt == 16'd1) ? w_frame_end : S_PAYLOAD;
            S_CHK:     if (w_xfer) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tgt_data  <= 1'b0;
            r_addr_lo   <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_bcnt      <= '0;
            r_pair      <= '0;
            r_inst_addr <= '0;
            r_data_addr <= '0;
            r_inst_d1   <= '0;
            r_inst_d2   <= '0;
            r_data_d1   <= '0;
            r_data_d2   <= '0;
            r_hold      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_xfer) begin
                    if (in_data == c_HDR_INST || in_data == c_HDR_DATA) begin
                        r_hold     <= 1'b1;
                        r_tgt_data <= (in_data == c_HDR_DATA);
                    end else if (in_data == c_HDR_RUN) begin
                        if (!r_err) r_hold <= 1'b0;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                S_ADDR_LO: if (w_xfer) r_addr_lo <= in_data;
                S_ADDR_HI: if (w_xfer) r_addr <= ADDRESS'({in_data, r_addr_lo});
                S_CNT_LO:  if (w_xfer) r_cnt <= {8'h00, in_data};
                S_CNT_HI:  if (w_xfer) begin
                    r_cnt  <= w_cnt_full;
                    r_bcnt <= 3'd0;
                end
                S_PAYLOAD: if (w_xfer) begin
                    r_pair <= w_pair_next[2*DATA-1:8];
                    r_bcnt <= r_bcnt + 3'd1;
                    // Publish the completed pair so it is stable during the WRITE strobe
                    if (r_bcnt == 3'd7) begin
                        if (r_tgt_data) begin
                            r_data_addr <= r_addr;
                            r_data_d1   <= w_pair_next[DATA-1:0];
                            r_data_d2   <= w_pair_next[2*DATA-1:DATA];
                        end else begin
                            r_inst_addr <= r_addr;
                            r_inst_d1   <= w_pair_next[DATA-1:0];
                            r_inst_d2   <= w_pair_next[2*DATA-1:DATA];
                        end
                    end
                end
                S_WRITE: begin
                    r_cnt  <= r_cnt - 16'd1;
                    r_addr <= r_addr + {{(ADDRESS-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running XOR from the header through the last payload byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum <= '0;
        end else if (w_xfer) begin
            if (r_state == S_IDLE)
                r_csum <= in_data;
            else if (r_state != S_CHK)
                r_csum <= r_csum ^ in_data;
        end
    end

    logic r_csum_err;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_csum_err <= 1'b0;
        else if (w_xfer && r_state == S_CHK && in_data != r_csum)
            r_csum_err <= 1'b1;
    end
    assign err = r_err | r_csum_err;
`else
    assign err = r_err;
`endif

    assign inst_we   = (r_state == S_WRITE) & ~r_tgt_data;
    assign data_we   = (r_state == S_WRITE) &  r_tgt_data;
    assign load_en   = inst_we | data_we;
    assign inst_addr = r_inst_addr;
    assign inst_d1   = r_inst_d1;
    assign inst_d2   = r_inst_d2;
    assign data_addr = r_data_addr;
    assign data_d1   = r_data_d1;
    assign data_d2   = r_data_d2;
    assign core_hold = r_hold;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
